button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner.sv | 71 +++++++
 tb/tb_button_conditioner.sv | 93 +++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// button_conditioner: synchronizes and debounces three push-buttons, then produces
// move strobes with auto-repeat for left/right and a single fire strobe for fire.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY = 15000000,
  parameter int REPEAT_PERIOD = 2500000
) (
  input  logic       board_clk,
  input  logic       reset,
  input  logic       btn_l,
  input  logic       btn_r,
  input  logic       btn_u,
  output logic [2:0] lvl,
  output logic       move_l,
  output logic       move_r,
  output logic       fire
);
  localparam logic [1:0] IDLE = 2'd0, DELAY = 2'd1, REPEAT = 2'd2;
  localparam logic [23:0] DB_LAST = 24'(DEBOUNCE_CYCLES - 1);
  localparam logic [23:0] RD_LAST = 24'(REPEAT_DELAY - 1);
  localparam logic [23:0] RP_LAST = 24'(REPEAT_PERIOD - 1);
  logic [2:0] s1, s2, lvl_nxt, rise, fall;
  logic [1:0] str;
  logic both;
  for (genvar i = 0; i < 3; i++) begin : g_db
    logic [23:0] cnt;
    logic diff;
    assign diff = s2[i] ^ lvl[i];
    assign lvl_nxt[i] = (diff && cnt == DB_LAST) ? ~lvl[i] : lvl[i];
    always_ff @(posedge board_clk or posedge reset)
      if (reset) cnt <= '0;
      else cnt <= (diff && cnt != DB_LAST) ? cnt + 24'd1 : '0;
  end
  assign rise = lvl_nxt & ~lvl;
  assign fall = ~lvl_nxt & lvl;
  // Strobes are decided from the next level so the first one lines up with lvl rising.
  for (genvar i = 0; i < 2; i++) begin : g_rep
    logic [1:0] st, st_n;
    logic [23:0] rc, rc_n;
    logic hit;
    assign hit = (st == DELAY && rc == RD_LAST) || (st == REPEAT && rc == RP_LAST);
    assign str[i] = rise[i] | (~fall[i] & hit);
    assign st_n = fall[i] ? IDLE : rise[i] ? DELAY : hit ? REPEAT : st;
    assign rc_n = (fall[i] || rise[i] || hit || st == IDLE) ? '0 : rc + 24'd1;
    always_ff @(posedge board_clk or posedge reset)
      if (reset) begin
        st <= IDLE;
        rc <= '0;
      end else begin
        st <= st_n;
        rc <= rc_n;
      end
  end
  assign both = lvl_nxt[0] & lvl_nxt[1];
  always_ff @(posedge board_clk or posedge reset)
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      lvl <= '0;
      move_l <= 1'b0;
      move_r <= 1'b0;
      fire <= 1'b0;
    end else begin
      s1 <= {btn_u, btn_r, btn_l};
      s2 <= s1;
      lvl <= lvl_nxt;
      move_l <= str[0] & ~both;
      move_r <= str[1] & ~both;
      fire <= rise[2];
    end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: vector-table and scoreboard bench for button_conditioner.
module tb_button_conditioner;
  logic board_clk = 1'b0;
  logic reset = 1'b1;
  logic btn_l = 1'b0, btn_r = 1'b0, btn_u = 1'b0;
  logic [2:0] lvl;
  logic move_l, move_r, fire;
  typedef struct {
    string tag;
    logic rst, l, r, u;
    logic [2:0] lv;
    logic ml, mr, fi;
  } vec_t;
  vec_t tv[$];
  vec_t sb[$];
  int total = 0, bad = 0;
  always #5 board_clk = ~board_clk;
  button_conditioner #(.DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)) dut (
    .board_clk(board_clk), .reset(reset), .btn_l(btn_l), .btn_r(btn_r), .btn_u(btn_u),
    .lvl(lvl), .move_l(move_l), .move_r(move_r), .fire(fire)
  );
  function automatic void add(string tag, logic rst, logic l, logic r, logic u,
                              logic [2:0] lv, logic ml, logic mr, logic fi);
    vec_t v;
    v.tag = tag; v.rst = rst; v.l = l; v.r = r; v.u = u;
    v.lv = lv; v.ml = ml; v.mr = mr; v.fi = fi;
    tv.push_back(v);
  endfunction
  function automatic logic win(int c, int a, int b);
    return c >= a && c < b;
  endfunction
  function automatic logic sched(int c, int first, int last);
    return c >= first && c <= last && (c - first) % 3 == 0;
  endfunction
  initial begin
    vec_t e;
    #1;
    total++;
    if ({lvl, move_l, move_r, fire} !== 6'b0) begin
      bad++;
      $display("FAIL reset_state: got lvl=%b ml=%b mr=%b fire=%b", lvl, move_l, move_r, fire);
    end
    for (int c = 0; c < 3; c++) add("reset", 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 40; c++)
      add("fire_hold", 1'b0, 1'b0, 1'b0, c < 30, {win(c, 6, 36), 2'b00}, 1'b0, 1'b0, c == 6);
    for (int c = 0; c < 12; c++)
      add("glitch_l", 1'b0, c < 3, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 50; c++)
      add("repeat_r", 1'b0, 1'b0, c < 40, 1'b0, {1'b0, win(c, 6, 46), 1'b0},
          1'b0, c == 6 || sched(c, 16, 43), 1'b0);
    for (int c = 0; c < 50; c++)
      add("both_held", 1'b0, c < 40, win(c, 8, 21), win(c, 10, 20),
          {win(c, 16, 26), win(c, 14, 27), win(c, 6, 46)},
          c == 6 || sched(c, 28, 43), 1'b0, c == 16);
    for (int c = 0; c < 56; c++)
      add("reset_mid", win(c, 20, 22), c < 45, 1'b0, 1'b0,
          {2'b00, win(c, 6, 20) || win(c, 28, 51)},
          c == 6 || c == 16 || c == 19 || c == 28 || sched(c, 38, 50), 1'b0, 1'b0);
    for (int i = 0; i < tv.size(); i++) begin
      @(posedge board_clk);
      #1;
      reset = tv[i].rst;
      btn_l = tv[i].l;
      btn_r = tv[i].r;
      btn_u = tv[i].u;
      sb.push_back(tv[i]);
      #1;
      e = sb.pop_front();
      total++;
      if ({lvl, move_l, move_r, fire} !== {e.lv, e.ml, e.mr, e.fi}) begin
        bad++;
        $display("FAIL %s step %0d: got lvl=%b ml=%b mr=%b fire=%b, want lvl=%b ml=%b mr=%b fire=%b",
                 e.tag, i, lvl, move_l, move_r, fire, e.lv, e.ml, e.mr, e.fi);
      end
    end
    reset = 1'b0;
    btn_l = 1'b0;
    btn_r = 1'b0;
    btn_u = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge board_clk);
      #2;
      total++;
      if ({lvl, move_l, move_r, fire} !== 6'b0) begin
        bad++;
        $display("FAIL expired_wait cycle %0d: got lvl=%b ml=%b mr=%b fire=%b",
                 c, lvl, move_l, move_r, fire);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
